// File: rtl/ecc_182_pkg.sv
// Shared SECDED constants for the 182-bit FIFO ECC: Hamming position map and
// per-check-bit coverage masks, common to the encoder and decoder builds.
package ecc_182_pkg;

  localparam int DATA_WIDTH   = 182;
  localparam int PARITY_WIDTH = 9;
  localparam int HAM_WIDTH    = 8;

  // Hamming position of data bit idx: positions 1..190 with powers of two skipped.
  function automatic int ham_pos(input int idx);
    int n;
    int res;
    n   = -1;
    res = 0;
    for (int p = 1; p < 256; p++) begin
      if ((p & (p - 1)) != 0) begin
        n++;
        if (n == idx) begin
          res = p;
        end else begin
          res = res;
        end
      end else begin
        n = n;
      end
    end
    return res;
  endfunction

  function automatic logic [HAM_WIDTH-1:0][DATA_WIDTH-1:0] build_masks();
    logic [HAM_WIDTH-1:0][DATA_WIDTH-1:0] m;
    int pos;
    m = '0;
    for (int d = 0; d < DATA_WIDTH; d++) begin
      pos = ham_pos(d);
      for (int i = 0; i < HAM_WIDTH; i++) begin
        if (((pos >> i) & 1) == 1) begin
          m[i][d] = 1'b1;
        end else begin
          m[i][d] = m[i][d];
        end
      end
    end
    return m;
  endfunction

  localparam logic [HAM_WIDTH-1:0][DATA_WIDTH-1:0] CHK_MASKS = build_masks();

endpackage

// File: rtl/ecc_182_enc.sv
// Combinational SECDED parity generator: 8 Hamming check bits plus an overall
// parity bit covering data and the Hamming bits.
module ecc_182_enc
  import ecc_182_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [PARITY_WIDTH-1:0] parity_o
);

  logic [HAM_WIDTH-1:0] ham_s;

  // Hamming check bits from the shared coverage masks.
  always_comb begin
    ham_s = '0;
    for (int i = 0; i < HAM_WIDTH; i++) begin
      ham_s[i] = ^(data_i & CHK_MASKS[i]);
    end
  end

  assign parity_o = {(^data_i) ^ (^ham_s), ham_s};

endmodule

// File: rtl/ecc_182_enc_pipe.sv
// Write-side SECDED encoder stage with lockstep encoders and a 1-deep
// valid/ready register. Optional error injection: define ECC_ENC_ERR_INJ_EN.
module ecc_182_enc_pipe
  import ecc_182_pkg::*;
#(
  parameter int FCNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ecc_fault_detc_en,
  input  logic                    bypass,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [PARITY_WIDTH-1:0] parity_out,
  output logic                    ecc_fault,
  output logic                    fault_sticky,
  output logic [FCNT_WIDTH-1:0]   fault_cnt,
  input  logic                    fault_clr
`ifdef ECC_ENC_ERR_INJ_EN
  ,
  input  logic                    inj_arm,
  input  logic                    inj_dbl,
  input  logic [7:0]              inj_pos,
  output logic                    inj_done
`endif
);

  localparam logic [FCNT_WIDTH-1:0] CNT_ONE = FCNT_WIDTH'(1);
  localparam logic [FCNT_WIDTH-1:0] CNT_MAX = {FCNT_WIDTH{1'b1}};

  logic [PARITY_WIDTH-1:0] parity_a_s;
  logic [PARITY_WIDTH-1:0] parity_b_s;
  logic                    accept_s;
  logic                    fault_s;
  logic [DATA_WIDTH-1:0]   inj_mask_s;

  logic                    out_vld_q,  out_vld_d;
  logic [DATA_WIDTH-1:0]   data_q,     data_d;
  logic [PARITY_WIDTH-1:0] parity_q,   parity_d;
  logic                    fault_q,    fault_d;
  logic                    sticky_q,   sticky_d;
  logic [FCNT_WIDTH-1:0]   cnt_q,      cnt_d;

  ecc_182_enc u0 (.data_i(data_in), .parity_o(parity_a_s));
  ecc_182_enc u1 (.data_i(data_in), .parity_o(parity_b_s));

  assign in_rdy   = ~out_vld_q | out_rdy;
  assign accept_s = in_vld & in_rdy;
  assign fault_s  = (parity_a_s != parity_b_s) & ecc_fault_detc_en & ~bypass;

`ifdef ECC_ENC_ERR_INJ_EN
  logic       inj_armed_q, inj_armed_d;
  logic       inj_dbl_q,   inj_dbl_d;
  logic [7:0] inj_pos_q,   inj_pos_d;
  logic       inj_done_q,  inj_done_d;
  logic       inj_fire_s;

  assign inj_fire_s = accept_s & inj_armed_q;

  // Arm on a valid pulse (out-of-range positions are ignored); disarm at use.
  always_comb begin
    inj_armed_d = inj_armed_q;
    inj_dbl_d   = inj_dbl_q;
    inj_pos_d   = inj_pos_q;
    inj_done_d  = inj_fire_s;
    inj_mask_s  = '0;
    if (inj_fire_s) begin
      inj_mask_s[inj_pos_q] = 1'b1;
      if (inj_dbl_q) begin
        inj_mask_s[(inj_pos_q == 8'd181) ? 8'd0 : inj_pos_q + 8'd1] = 1'b1;
      end else begin
        inj_mask_s = inj_mask_s;
      end
    end else begin
      inj_mask_s = '0;
    end
    if (inj_arm && (inj_pos <= 8'd181)) begin
      inj_armed_d = 1'b1;
      inj_dbl_d   = inj_dbl;
      inj_pos_d   = inj_pos;
    end else if (inj_fire_s) begin
      inj_armed_d = 1'b0;
    end else begin
      inj_armed_d = inj_armed_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_armed_q <= 1'b0;
      inj_dbl_q   <= 1'b0;
      inj_pos_q   <= 8'd0;
      inj_done_q  <= 1'b0;
    end else begin
      inj_armed_q <= inj_armed_d;
      inj_dbl_q   <= inj_dbl_d;
      inj_pos_q   <= inj_pos_d;
      inj_done_q  <= inj_done_d;
    end
  end

  assign inj_done = inj_done_q;
`else
  assign inj_mask_s = '0;
`endif

  // Pipeline register: load on accept, drop when drained with nothing behind.
  always_comb begin
    out_vld_d = out_vld_q;
    data_d    = data_q;
    parity_d  = parity_q;
    fault_d   = fault_q;
    if (accept_s) begin
      out_vld_d = 1'b1;
      data_d    = data_in ^ inj_mask_s;
      parity_d  = bypass ? '0 : parity_a_s;
      fault_d   = fault_s;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
      fault_d   = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end
  end

  // Fault bookkeeping counts only at acceptance, so a stalled word is counted once.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (fault_clr) begin
      sticky_d = accept_s & fault_s;
      cnt_d    = (accept_s & fault_s) ? CNT_ONE : '0;
    end else if (accept_s && fault_s) begin
      sticky_d = 1'b1;
      cnt_d    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    end else begin
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      data_q    <= '0;
      parity_q  <= '0;
      fault_q   <= 1'b0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      fault_q   <= fault_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_vld      = out_vld_q;
  assign data_out     = data_q;
  assign parity_out   = parity_q;
  assign ecc_fault    = fault_q;
  assign fault_sticky = sticky_q;
  assign fault_cnt    = cnt_q;

endmodule

// File: tb/tb_ecc_182_enc_pipe.sv
// Directed bench for ecc_182_enc_pipe: encoding vectors, handshake, lockstep
// faults, counter saturation/clear, reset, and injection when ECC_ENC_ERR_INJ_EN.
module tb_ecc_182_enc_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ecc_fault_detc_en;
  logic         bypass;
  logic         in_vld;
  logic         in_rdy;
  logic [181:0] data_in;
  logic         out_vld;
  logic         out_rdy;
  logic [181:0] data_out;
  logic [8:0]   parity_out;
  logic         ecc_fault;
  logic         fault_sticky;
  logic [7:0]   fault_cnt;
  logic         fault_clr;
`ifdef ECC_ENC_ERR_INJ_EN
  logic         inj_arm;
  logic         inj_dbl;
  logic [7:0]   inj_pos;
  logic         inj_done;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0]   par_force;
  logic [181:0] words [16];
  logic [181:0] exp_q [$];
  logic [181:0] exp_w;
  logic [3:0]   rdy_pat;

  ecc_182_enc_pipe dut (
    .clk(clk), .rst_n(rst_n), .ecc_fault_detc_en(ecc_fault_detc_en), .bypass(bypass),
    .in_vld(in_vld), .in_rdy(in_rdy), .data_in(data_in), .out_vld(out_vld),
    .out_rdy(out_rdy), .data_out(data_out), .parity_out(parity_out),
    .ecc_fault(ecc_fault), .fault_sticky(fault_sticky), .fault_cnt(fault_cnt),
    .fault_clr(fault_clr)
`ifdef ECC_ENC_ERR_INJ_EN
    , .inj_arm(inj_arm), .inj_dbl(inj_dbl), .inj_pos(inj_pos), .inj_done(inj_done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference SECDED: XOR the Hamming positions of the set data bits.
  function automatic logic [8:0] ref_par(input logic [181:0] d);
    logic [7:0] syn;
    int idx;
    syn = 8'h00;
    idx = 0;
    for (int p = 1; p <= 190; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[idx]) syn = syn ^ 8'(p);
        idx++;
      end
    end
    return {(^d) ^ (^syn), syn};
  endfunction

  function automatic logic [181:0] rnd_word();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[181:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one cycle; optionally corrupt bit 3 of encoder u1's parity.
  task automatic put_word(input logic [181:0] d, input logic bad);
    in_vld  = 1'b1;
    data_in = d;
    if (bad) begin
      par_force = ref_par(d) ^ 9'h008;
      force dut.parity_b_s = par_force;
    end
    tick();
    in_vld = 1'b0;
    if (bad) release dut.parity_b_s;
  endtask

  initial begin
    int sent, recv;
    logic acc, cons;
    rst_n = 1'b0; ecc_fault_detc_en = 1'b1; bypass = 1'b0; in_vld = 1'b0;
    data_in = '0; out_rdy = 1'b0; fault_clr = 1'b0;
`ifdef ECC_ENC_ERR_INJ_EN
    inj_arm = 1'b0; inj_dbl = 1'b0; inj_pos = 8'd0;
`endif
    repeat (3) tick();
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_data", data_out, 182'h0);
    check("rst_parity", parity_out, 9'h000);
    check("rst_fault", {ecc_fault, fault_sticky, fault_cnt}, 10'h000);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_in_rdy", in_rdy, 1'b1);

    // Hand-computed vectors: bit0->pos3, bit1->pos5, bit4->pos9, bit181->pos190.
    out_rdy = 1'b1;
    put_word(182'h0, 1'b0);
    check("zero_vld", out_vld, 1'b1);
    check("zero_par", parity_out, 9'h000);
    put_word(182'h1, 1'b0);
    check("bit0_par", parity_out, 9'h103);
    put_word(182'h2, 1'b0);
    check("bit1_par", parity_out, 9'h105);
    put_word(182'h10, 1'b0);
    check("bit4_par", parity_out, 9'h109);
    exp_w = '0; exp_w[181] = 1'b1;
    put_word(exp_w, 1'b0);
    check("bit181_par", parity_out, 9'h1BE);
    check("bit181_data", data_out, exp_w);
    tick();
    check("drain_vld", out_vld, 1'b0);

    // Back-to-back: one word per cycle with out_rdy held high.
    for (int i = 0; i < 8; i++) begin
      exp_w = rnd_word();
      check("b2b_rdy", in_rdy, 1'b1);
      put_word(exp_w, 1'b0);
      check("b2b_vld", out_vld, 1'b1);
      check("b2b_data", data_out, exp_w);
      check("b2b_par", parity_out, ref_par(exp_w));
    end
    tick();

    // Streaming with out_rdy pattern 1,0,0,1: order kept, no loss or duplication.
    for (int i = 0; i < 16; i++) words[i] = rnd_word();
    rdy_pat = 4'b1001;
    sent = 0; recv = 0;
    for (int c = 0; c < 200 && recv < 16; c++) begin
      out_rdy = rdy_pat[c % 4];
      in_vld  = (sent < 16);
      data_in = (sent < 16) ? words[sent] : '0;
      #1;
      acc  = in_vld & in_rdy;
      cons = out_vld & out_rdy;
      if (cons) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 1'b1, 1'b0);
        end else begin
          exp_w = exp_q.pop_front();
          check("stream_data", data_out, exp_w);
          check("stream_par", parity_out, ref_par(exp_w));
        end
        recv++;
      end
      if (acc) begin
        exp_q.push_back(words[sent]);
        sent++;
      end
      tick();
    end
    in_vld = 1'b0;
    check("stream_recv", recv, 16);
    check("stream_left", exp_q.size(), 0);
    out_rdy = 1'b1;
    tick();

    // Lockstep fault, then a 3-cycle stall must not recount.
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    out_rdy = 1'b0;
    exp_w = rnd_word();
    put_word(exp_w, 1'b1);
    check("flt_bit", ecc_fault, 1'b1);
    check("flt_sticky", fault_sticky, 1'b1);
    check("flt_cnt", fault_cnt, 8'd1);
    check("flt_par_a", parity_out, ref_par(exp_w));
    repeat (3) tick();
    check("stall_cnt", fault_cnt, 8'd1);
    check("stall_hold", {ecc_fault, out_vld}, 2'b11);
    check("stall_data", data_out, exp_w);
    out_rdy = 1'b1;
    tick();

    ecc_fault_detc_en = 1'b0;
    put_word(rnd_word(), 1'b1);
    check("noen_fault", ecc_fault, 1'b0);
    check("noen_cnt", fault_cnt, 8'd1);
    ecc_fault_detc_en = 1'b1;
    bypass = 1'b1;
    put_word(182'h1, 1'b1);
    check("byp_fault", ecc_fault, 1'b0);
    check("byp_par", parity_out, 9'h000);
    check("byp_cnt", fault_cnt, 8'd1);
    bypass = 1'b0;

    // Saturation at 255, then clear colliding with a fault leaves count 1.
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("clr_cnt", {fault_sticky, fault_cnt}, 9'h000);
    for (int i = 0; i < 255; i++) put_word(182'(i + 1), 1'b1);
    check("sat_cnt255", fault_cnt, 8'd255);
    put_word(182'h5a5a, 1'b1);
    check("sat_hold", fault_cnt, 8'd255);
    fault_clr = 1'b1;
    put_word(182'h3c3c, 1'b1);
    fault_clr = 1'b0;
    check("clrflt_cnt", fault_cnt, 8'd1);
    check("clrflt_sticky", fault_sticky, 1'b1);

`ifdef ECC_ENC_ERR_INJ_EN
    exp_w = rnd_word();
    inj_arm = 1'b1; inj_pos = 8'd0; inj_dbl = 1'b0; tick(); inj_arm = 1'b0;
    put_word(exp_w, 1'b0);
    check("inj1_data", data_out, exp_w ^ 182'h1);
    check("inj1_par", parity_out, ref_par(exp_w));
    check("inj1_done", inj_done, 1'b1);
    put_word(exp_w, 1'b0);
    check("inj1_oneshot", data_out, exp_w);
    inj_arm = 1'b1; inj_pos = 8'd181; inj_dbl = 1'b1; tick(); inj_arm = 1'b0;
    put_word(exp_w, 1'b0);
    check("inj2_data", data_out, exp_w ^ {1'b1, 180'h0, 1'b1});
`endif

    // Reset while a word is held drops it.
    out_rdy = 1'b0;
    put_word(182'hABC, 1'b0);
    check("mid_vld", out_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_vld", out_vld, 1'b0);
    check("midrst_data", data_out, 182'h0);
    check("midrst_rdy", in_rdy, 1'b1);
    check("midrst_cnt", fault_cnt, 8'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
